layer_ctrl_fsm: RTL and testbench

Parametrised layer-sequencing controller for the inference accelerator datapath. It steps through weight load, data load/execute, accumulate and write-out for a configurable number of input tiles per output-channel group, and for a configurable number of groups. It generates its own tile and group indices instead of relying on an external last-tile flag, and supports abort and configuration-error reporting. It sits between the host command interface and the weight-loader, data-loader/MAC, adder and output-writer engines.

---
 rtl/layer_ctrl_fsm_if.sv | 36 +++
 rtl/layer_ctrl_fsm.sv | 128 ++++++++++++
 tb/tb_layer_ctrl_fsm.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/layer_ctrl_fsm_if.sv
// layer_ctrl_fsm_if: host command and engine handshake bundle; slave = controller, master = host/engines.
interface layer_ctrl_fsm_if #(
  parameter int TILE_W  = 8,
  parameter int GROUP_W = 4
);
  logic               start;
  logic               abort;
  logic [TILE_W-1:0]  cfg_num_tiles;
  logic [GROUP_W-1:0] cfg_num_groups;
  logic               load_weight_done;
  logic               load_data_exec_done;
  logic               adder_done;
  logic               write_output_done;
  logic               load_weight_start;
  logic               exec_start;
  logic               adder_en;
  logic               write_start;
  logic [TILE_W-1:0]  tile_idx;
  logic [GROUP_W-1:0] group_idx;
  logic               busy;
  logic               done;
  logic               aborted;
  logic               cfg_err;
  modport slave (
    input  start, abort, cfg_num_tiles, cfg_num_groups,
           load_weight_done, load_data_exec_done, adder_done, write_output_done,
    output load_weight_start, exec_start, adder_en, write_start,
           tile_idx, group_idx, busy, done, aborted, cfg_err
  );
  modport master (
    output start, abort, cfg_num_tiles, cfg_num_groups,
           load_weight_done, load_data_exec_done, adder_done, write_output_done,
    input  load_weight_start, exec_start, adder_en, write_start,
           tile_idx, group_idx, busy, done, aborted, cfg_err
  );
endinterface

// File: rtl/layer_ctrl_fsm.sv
// layer_ctrl_fsm: sequences weight load, exec, add, write per tile/group; ports clk, rst (async high), bus (layer_ctrl_fsm_if.slave), perf_cycles only when CTRL_PERF_CNT_EN is defined.
module layer_ctrl_fsm #(
  parameter int TILE_W  = 8,
  parameter int GROUP_W = 4,
  parameter int PERF_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  layer_ctrl_fsm_if.slave      bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]    perf_cycles
`endif
);
  typedef enum logic [2:0] {
    IDLE, LOAD_WEIGHT, LOAD_DATA_EXEC, ADD_OUT, WRITE_OUT, INTER
  } state_t;
  state_t             state_q, state_d;
  logic [TILE_W-1:0]  tile_q, tile_d, nt_q, nt_d;
  logic [GROUP_W-1:0] group_q, group_d, ng_q, ng_d;
  logic lws_q, lws_d, es_q, es_d, aen_q, aen_d, ws_q, ws_d;
  logic busy_q, busy_d, done_q, done_d, aborted_q, aborted_d, cfg_err_q, cfg_err_d;
  always_comb begin
    state_d   = state_q;
    tile_d    = tile_q;
    group_d   = group_q;
    nt_d      = nt_q;
    ng_d      = ng_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cfg_err_d = 1'b0;
    if (state_q != IDLE && bus.abort) begin
      state_d   = IDLE;
      tile_d    = '0;
      group_d   = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          if (bus.cfg_num_tiles != '0 && bus.cfg_num_groups != '0) begin
            state_d = LOAD_WEIGHT;
            nt_d    = bus.cfg_num_tiles;
            ng_d    = bus.cfg_num_groups;
            tile_d  = '0;
            group_d = '0;
          end else cfg_err_d = 1'b1;
        end
        LOAD_WEIGHT:    state_d = bus.load_weight_done    ? LOAD_DATA_EXEC : state_q;
        LOAD_DATA_EXEC: state_d = bus.load_data_exec_done ? ADD_OUT        : state_q;
        ADD_OUT:        state_d = bus.adder_done          ? WRITE_OUT      : state_q;
        WRITE_OUT:      state_d = bus.write_output_done   ? INTER          : state_q;
        INTER: begin
          // Latched counts are nonzero, so count-1 never underflows and the compare cannot wrap.
          if (tile_q < nt_q - TILE_W'(1)) begin
            tile_d  = tile_q + TILE_W'(1);
            state_d = LOAD_DATA_EXEC;
          end else if (group_q < ng_q - GROUP_W'(1)) begin
            tile_d  = '0;
            group_d = group_q + GROUP_W'(1);
            state_d = LOAD_WEIGHT;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Outputs decode next state so the registered copies line up with the state they describe.
    lws_d  = state_d == LOAD_WEIGHT    && state_q != LOAD_WEIGHT;
    es_d   = state_d == LOAD_DATA_EXEC && state_q != LOAD_DATA_EXEC;
    aen_d  = state_d == ADD_OUT;
    ws_d   = state_d == WRITE_OUT      && state_q != WRITE_OUT;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tile_q    <= '0;
      group_q   <= '0;
      nt_q      <= '0;
      ng_q      <= '0;
      lws_q     <= 1'b0;
      es_q      <= 1'b0;
      aen_q     <= 1'b0;
      ws_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tile_q    <= tile_d;
      group_q   <= group_d;
      nt_q      <= nt_d;
      ng_q      <= ng_d;
      lws_q     <= lws_d;
      es_q      <= es_d;
      aen_q     <= aen_d;
      ws_q      <= ws_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cfg_err_q <= cfg_err_d;
    end
  end
  assign bus.load_weight_start = lws_q;
  assign bus.exec_start        = es_q;
  assign bus.adder_en          = aen_q;
  assign bus.write_start       = ws_q;
  assign bus.tile_idx          = tile_q;
  assign bus.group_idx         = group_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.aborted           = aborted_q;
  assign bus.cfg_err           = cfg_err_q;
`ifdef CTRL_PERF_CNT_EN
  logic [PERF_W-1:0] perf_q, perf_d;
  // An accepted start is the only IDLE->LOAD_WEIGHT move; the count then tracks registered busy.
  always_comb perf_d = (state_q == IDLE && state_d == LOAD_WEIGHT) ? '0 :
                       (busy_q && perf_q != '1) ? perf_q + PERF_W'(1) : perf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_layer_ctrl_fsm.sv
// tb_layer_ctrl_fsm: table-driven vectors plus multi-cycle sequences for layer_ctrl_fsm.
module tb_layer_ctrl_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  layer_ctrl_fsm_if #(.TILE_W(8), .GROUP_W(4)) bus ();
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] perf_cycles;
  layer_ctrl_fsm #(.TILE_W(8), .GROUP_W(4), .PERF_W(32)) dut (.clk(clk), .rst(rst), .bus(bus), .perf_cycles(perf_cycles));
`else
  layer_ctrl_fsm #(.TILE_W(8), .GROUP_W(4), .PERF_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  typedef struct {
    logic       st, ab;
    logic [7:0] nt;
    logic [3:0] ng;
    logic       lwd, lde, add, wod;
    logic [7:0] ef;
    logic [7:0] et;
    logic [3:0] eg;
  } vec_t;
  vec_t vq[$];
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // flag order: load_weight_start, exec_start, adder_en, write_start, busy, done, aborted, cfg_err
  function automatic logic [7:0] flags();
    return {bus.load_weight_start, bus.exec_start, bus.adder_en, bus.write_start,
            bus.busy, bus.done, bus.aborted, bus.cfg_err};
  endfunction
  task automatic add(input logic st, ab, input logic [7:0] nt, input logic [3:0] ng,
                     input logic lwd, lde, ad, wod, input logic [7:0] ef, input logic [7:0] et, input logic [3:0] eg);
    vec_t v;
    v.st = st; v.ab = ab; v.nt = nt; v.ng = ng;
    v.lwd = lwd; v.lde = lde; v.add = ad; v.wod = wod;
    v.ef = ef; v.et = et; v.eg = eg;
    vq.push_back(v);
  endtask
  task automatic drive(input logic st, ab, input logic [7:0] nt, input logic [3:0] ng, input logic lwd, lde, ad, wod);
    bus.start = st; bus.abort = ab; bus.cfg_num_tiles = nt; bus.cfg_num_groups = ng;
    bus.load_weight_done = lwd; bus.load_data_exec_done = lde; bus.adder_done = ad; bus.write_output_done = wod;
  endtask
  initial begin
    int nlw, nes, ndone, maxt;
    logic fin, p_lws, p_es, p_aen, p_ws;
    logic [7:0] tq[$];
    logic [3:0] gq[$];
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // tiles=1 groups=1, done inputs tied high
    add(1,0,8'd1,4'd1, 1,1,1,1, 8'b1000_1000, 0, 0);
    add(0,0,8'd1,4'd1, 1,1,1,1, 8'b0100_1000, 0, 0);
    add(0,0,8'd1,4'd1, 1,1,1,1, 8'b0010_1000, 0, 0);
    add(0,0,8'd1,4'd1, 1,1,1,1, 8'b0001_1000, 0, 0);
    add(0,0,8'd1,4'd1, 1,1,1,1, 8'b0000_1000, 0, 0);
    add(0,0,8'd1,4'd1, 1,1,1,1, 8'b0000_0100, 0, 0);
    // zero counts are rejected
    add(1,0,8'd0,4'd2, 0,0,0,0, 8'b0000_0001, 0, 0);
    add(0,0,8'd0,4'd0, 0,0,0,0, 8'b0000_0000, 0, 0);
    add(1,0,8'd3,4'd0, 0,0,0,0, 8'b0000_0001, 0, 0);
    // abort in ADD_OUT together with adder_done, then abort in IDLE
    add(1,0,8'd2,4'd1, 0,0,0,0, 8'b1000_1000, 0, 0);
    add(0,0,8'd2,4'd1, 1,0,0,0, 8'b0100_1000, 0, 0);
    add(0,0,8'd2,4'd1, 0,1,0,0, 8'b0010_1000, 0, 0);
    add(0,1,8'd2,4'd1, 0,0,1,0, 8'b0000_0010, 0, 0);
    add(0,1,8'd2,4'd1, 0,0,0,0, 8'b0000_0000, 0, 0);
    // spurious done inputs and start while busy in LOAD_WEIGHT
    add(1,0,8'd2,4'd2, 0,0,0,0, 8'b1000_1000, 0, 0);
    add(1,0,8'd0,4'd0, 0,0,1,0, 8'b0000_1000, 0, 0);
    add(0,0,8'd0,4'd0, 0,1,0,1, 8'b0000_1000, 0, 0);
    add(1,0,8'd5,4'd5, 1,0,0,0, 8'b0100_1000, 0, 0);
    add(0,1,8'd0,4'd0, 0,0,0,0, 8'b0000_0010, 0, 0);
    #2;
    chk("reset_flags", flags(), 8'h00);
    chk("reset_tile", bus.tile_idx, 0);
    chk("reset_group", bus.group_idx, 0);
`ifdef CTRL_PERF_CNT_EN
    chk("reset_perf", perf_cycles, 0);
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].st, vq[i].ab, vq[i].nt, vq[i].ng, vq[i].lwd, vq[i].lde, vq[i].add, vq[i].wod);
      @(negedge clk);
      chk($sformatf("vec%0d_flags", i), flags(), vq[i].ef);
      chk($sformatf("vec%0d_tile", i), bus.tile_idx, vq[i].et);
      chk($sformatf("vec%0d_group", i), bus.group_idx, vq[i].eg);
`ifdef CTRL_PERF_CNT_EN
      if (i == 5) chk("perf_1x1", perf_cycles, 5);
      if (i == 12) chk("perf_hold_abort", perf_cycles, 3);
`endif
    end
    // tiles=3 groups=2, each done input returned one cycle after its start pulse
    drive(1, 0, 8'd3, 4'd2, 0, 0, 0, 0);
    nlw = 0; nes = 0; ndone = 0; fin = 0;
    p_lws = 0; p_es = 0; p_aen = 0; p_ws = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      bus.start = (c % 3 == 2);
      if (bus.load_weight_start) nlw++;
      if (bus.exec_start) begin nes++; tq.push_back(bus.tile_idx); gq.push_back(bus.group_idx); end
      if (bus.done) begin ndone++; fin = 1; chk("done_busy_low", bus.busy, 0); end
      bus.load_weight_done = p_lws; bus.load_data_exec_done = p_es;
      bus.adder_done = p_aen; bus.write_output_done = p_ws;
      p_lws = bus.load_weight_start; p_es = bus.exec_start; p_aen = bus.adder_en; p_ws = bus.write_start;
    end
    chk("run32_finished", fin, 1);
    chk("run32_lws_count", nlw, 2);
    chk("run32_exec_count", nes, 6);
    chk("run32_done_count", ndone, 1);
    for (int i = 0; i < 6 && i < tq.size(); i++) begin
      chk($sformatf("run32_tile%0d", i), tq[i], i % 3);
      chk($sformatf("run32_group%0d", i), gq[i], i / 3);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_done_flags", flags(), 8'h00);
    // maximum tile count, no index wrap
    drive(1, 0, 8'd255, 4'd2, 1, 1, 1, 1);
    nlw = 0; nes = 0; maxt = 0; fin = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      bus.start = 0;
      if (bus.load_weight_start) nlw++;
      if (bus.exec_start) nes++;
      if (bus.tile_idx > maxt) maxt = bus.tile_idx;
      if (bus.done) fin = 1;
    end
    chk("max_finished", fin, 1);
    chk("max_exec_count", nes, 510);
    chk("max_lws_count", nlw, 2);
    chk("max_tile_idx", maxt, 254);
    // asynchronous reset in WRITE_OUT of the second tile
    drive(1, 0, 8'd2, 4'd1, 1, 1, 1, 1);
    fin = 0;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      bus.start = 0;
      if (bus.write_start && bus.tile_idx == 8'd1) fin = 1;
    end
    chk("rst_reached_write", fin, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_flags", flags(), 8'h00);
    chk("async_rst_tile", bus.tile_idx, 0);
    #1;
    rst = 1'b0;
    drive(1, 0, 8'd1, 4'd1, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_start", flags(), 8'b1000_1000);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_exec", flags(), 8'b0100_1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
